// File: rtl/sram_bus_arbiter.sv
// Shares one single-ported SRAM bus between the fetch port and the data port.
// Each access holds the bus for WAIT_CYCLES cycles and then acks its port for one cycle.
module sram_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter bit RR_MODE     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        lastData_q;
  logic        ifAck_q;
  logic        dAck_q;
  logic [31:0] ifData_q;
  logic [31:0] dRdata_q;
  logic        ce_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        grantD;
  logic        grantIf;

  // With both ports requesting, round-robin hands the bus to whichever port lost last time.
  always_comb begin
    grantD  = 1'b0;
    grantIf = 1'b0;
    if (d_req_i && if_req_i) begin
      if (RR_MODE && lastData_q) grantIf = 1'b1;
      else                       grantD  = 1'b1;
    end else if (d_req_i) begin
      grantD = 1'b1;
    end else if (if_req_i) begin
      grantIf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      lastData_q <= 1'b1;
      ifAck_q    <= 1'b0;
      dAck_q     <= 1'b0;
      ifData_q   <= 32'd0;
      dRdata_q   <= 32'd0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      ifAck_q <= 1'b0;
      dAck_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantD) begin
            state_q    <= BUSY_D;
            cnt_q      <= CntLoad;
            lastData_q <= 1'b1;
            ce_q       <= 1'b1;
            we_q       <= d_we_i;
            sel_q      <= d_sel_i;
            addr_q     <= d_addr_i;
            wdata_q    <= d_wdata_i;
          end else if (grantIf) begin
            state_q    <= BUSY_IF;
            cnt_q      <= CntLoad;
            lastData_q <= 1'b0;
            ce_q       <= 1'b1;
            we_q       <= 1'b0;
            sel_q      <= 4'hF;
            addr_q     <= if_addr_i;
          end
        end
        BUSY_IF: begin
          if (cnt_q == 4'd0) begin
            state_q  <= IDLE;
            ce_q     <= 1'b0;
            ifData_q <= mem_rdata_i;
            ifAck_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        BUSY_D: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            dAck_q  <= 1'b1;
            if (!we_q) dRdata_q <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_data_o   = ifData_q;
  assign if_ack_o    = ifAck_q;
  assign d_rdata_o   = dRdata_q;
  assign d_ack_o     = dAck_q;
  assign mem_ce_o    = ce_q;
  assign mem_we_o    = we_q;
  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Gated by reset so the stall request reads 0 while the block is held in reset.
  assign stallreq_o = rst & ((if_req_i & ~ifAck_q) | (d_req_i & ~dAck_q));

  assert property (@(posedge clk) (WAIT_CYCLES >= 1) && (WAIT_CYCLES <= 15));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: u0 is W=2 fixed priority, u1 is W=1 fixed priority, u2 is W=1 round-robin.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [3:0]  dSel = '0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic [31:0] memRdata = '0;

  logic [31:0] ifData[3];
  logic [31:0] dRdata[3];
  logic [31:0] memAddr[3];
  logic [31:0] memWdata[3];
  logic [3:0]  memSel[3];
  logic        ifAck[3];
  logic        dAck[3];
  logic        memCe[3];
  logic        memWe[3];
  logic        stall[3];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.WAIT_CYCLES(2), .RR_MODE(1'b0)) u0 (
    .clk(clk), .rst(rst), .if_req_i(ifReq), .if_addr_i(ifAddr), .if_data_o(ifData[0]),
    .if_ack_o(ifAck[0]), .d_req_i(dReq), .d_we_i(dWe), .d_sel_i(dSel), .d_addr_i(dAddr),
    .d_wdata_i(dWdata), .d_rdata_o(dRdata[0]), .d_ack_o(dAck[0]), .mem_ce_o(memCe[0]),
    .mem_we_o(memWe[0]), .mem_sel_o(memSel[0]), .mem_addr_o(memAddr[0]),
    .mem_wdata_o(memWdata[0]), .mem_rdata_i(memRdata), .stallreq_o(stall[0]));

  sram_bus_arbiter #(.WAIT_CYCLES(1), .RR_MODE(1'b0)) u1 (
    .clk(clk), .rst(rst), .if_req_i(ifReq), .if_addr_i(ifAddr), .if_data_o(ifData[1]),
    .if_ack_o(ifAck[1]), .d_req_i(dReq), .d_we_i(dWe), .d_sel_i(dSel), .d_addr_i(dAddr),
    .d_wdata_i(dWdata), .d_rdata_o(dRdata[1]), .d_ack_o(dAck[1]), .mem_ce_o(memCe[1]),
    .mem_we_o(memWe[1]), .mem_sel_o(memSel[1]), .mem_addr_o(memAddr[1]),
    .mem_wdata_o(memWdata[1]), .mem_rdata_i(memRdata), .stallreq_o(stall[1]));

  sram_bus_arbiter #(.WAIT_CYCLES(1), .RR_MODE(1'b1)) u2 (
    .clk(clk), .rst(rst), .if_req_i(ifReq), .if_addr_i(ifAddr), .if_data_o(ifData[2]),
    .if_ack_o(ifAck[2]), .d_req_i(dReq), .d_we_i(dWe), .d_sel_i(dSel), .d_addr_i(dAddr),
    .d_wdata_i(dWdata), .d_rdata_o(dRdata[2]), .d_ack_o(dAck[2]), .mem_ce_o(memCe[2]),
    .mem_we_o(memWe[2]), .mem_sel_o(memSel[2]), .mem_addr_o(memAddr[2]),
    .mem_wdata_o(memWdata[2]), .mem_rdata_i(memRdata), .stallreq_o(stall[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ifReq = 1'b0; dReq = 1'b0; dWe = 1'b0; dSel = 4'h0;
    ifAddr = '0; dAddr = '0; dWdata = '0; memRdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; ifReq = 1'b1; dReq = 1'b1; dWe = 1'b0; dSel = 4'hF;
    dAddr = 32'h40; ifAddr = 32'h100; memRdata = 32'h0;
    tick();
    checks++; if (memCe[0] !== 1'b0) $display("[TB] FAIL rst_ce got %b want 0", memCe[0]); else passes++;
    checks++; if (ifAck[0] !== 1'b0 || dAck[0] !== 1'b0) $display("[TB] FAIL rst_acks got %b%b want 00", ifAck[0], dAck[0]); else passes++;
    checks++; if (ifData[0] !== 32'h0 || dRdata[0] !== 32'h0) $display("[TB] FAIL rst_data got %h/%h want 0/0", ifData[0], dRdata[0]); else passes++;
    checks++; if (stall[0] !== 1'b0) $display("[TB] FAIL rst_stall got %b want 0", stall[0]); else passes++;
    checks++; if (memAddr[0] !== 32'h0 || memSel[0] !== 4'h0 || memWe[0] !== 1'b0) $display("[TB] FAIL rst_bus got %h/%h/%b want 0/0/0", memAddr[0], memSel[0], memWe[0]); else passes++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (memCe[0] !== 1'b1 || memAddr[0] !== 32'h40) $display("[TB] FAIL rst_first_grant got ce=%b addr=%h want ce=1 addr=40", memCe[0], memAddr[0]); else passes++;
    ifReq = 1'b0; dReq = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_fetch();
    ifReq = 1'b1; ifAddr = 32'h100; memRdata = 32'h3C011234;
    tick();
    checks++; if (memCe[0] !== 1'b1 || memAddr[0] !== 32'h100 || memSel[0] !== 4'hF || memWe[0] !== 1'b0) $display("[TB] FAIL fetch_bus1 got ce=%b addr=%h sel=%h we=%b want 1/100/f/0", memCe[0], memAddr[0], memSel[0], memWe[0]); else passes++;
    checks++; if (stall[0] !== 1'b1 || ifAck[0] !== 1'b0) $display("[TB] FAIL fetch_stall1 got stall=%b ack=%b want 1/0", stall[0], ifAck[0]); else passes++;
    tick();
    checks++; if (memCe[0] !== 1'b1 || memAddr[0] !== 32'h100 || ifAck[0] !== 1'b0) $display("[TB] FAIL fetch_bus2 got ce=%b addr=%h ack=%b want 1/100/0", memCe[0], memAddr[0], ifAck[0]); else passes++;
    tick();
    checks++; if (ifAck[0] !== 1'b1 || ifData[0] !== 32'h3C011234) $display("[TB] FAIL fetch_ack got ack=%b data=%h want 1/3c011234", ifAck[0], ifData[0]); else passes++;
    checks++; if (memCe[0] !== 1'b0 || stall[0] !== 1'b0 || dAck[0] !== 1'b0) $display("[TB] FAIL fetch_ackcyc got ce=%b stall=%b dack=%b want 0/0/0", memCe[0], stall[0], dAck[0]); else passes++;
    ifReq = 1'b0; memRdata = 32'hAAAA5555;
    tick();
    checks++; if (ifAck[0] !== 1'b0 || ifData[0] !== 32'h3C011234 || memCe[0] !== 1'b0) $display("[TB] FAIL fetch_after got ack=%b data=%h ce=%b want 0/3c011234/0", ifAck[0], ifData[0], memCe[0]); else passes++;
  endtask

  task automatic test_write_read();
    dReq = 1'b1; dWe = 1'b1; dSel = 4'b0011; dAddr = 32'h20; dWdata = 32'hDEADBEEF; memRdata = 32'h12345678;
    tick();
    checks++; if (memCe[0] !== 1'b1 || memWe[0] !== 1'b1 || memSel[0] !== 4'b0011 || memAddr[0] !== 32'h20 || memWdata[0] !== 32'hDEADBEEF) $display("[TB] FAIL wr_bus got ce=%b we=%b sel=%h addr=%h wd=%h want 1/1/3/20/deadbeef", memCe[0], memWe[0], memSel[0], memAddr[0], memWdata[0]); else passes++;
    dAddr = 32'h99; dWdata = 32'h0;
    tick();
    checks++; if (memAddr[0] !== 32'h20 || memWdata[0] !== 32'hDEADBEEF || dAck[0] !== 1'b0) $display("[TB] FAIL wr_hold got addr=%h wd=%h ack=%b want 20/deadbeef/0", memAddr[0], memWdata[0], dAck[0]); else passes++;
    tick();
    checks++; if (dAck[0] !== 1'b1 || dRdata[0] !== 32'h0 || ifAck[0] !== 1'b0) $display("[TB] FAIL wr_ack got ack=%b rdata=%h iack=%b want 1/0/0", dAck[0], dRdata[0], ifAck[0]); else passes++;
    dWe = 1'b0; dSel = 4'hF; dAddr = 32'h20; memRdata = 32'h0000BEEF;
    tick();
    checks++; if (memCe[0] !== 1'b1 || memWe[0] !== 1'b0 || memAddr[0] !== 32'h20 || dAck[0] !== 1'b0) $display("[TB] FAIL rd_b2b got ce=%b we=%b addr=%h ack=%b want 1/0/20/0", memCe[0], memWe[0], memAddr[0], dAck[0]); else passes++;
    tick();
    tick();
    checks++; if (dAck[0] !== 1'b1 || dRdata[0] !== 32'h0000BEEF) $display("[TB] FAIL rd_ack got ack=%b rdata=%h want 1/0000beef", dAck[0], dRdata[0]); else passes++;
    dReq = 1'b0; memRdata = 32'hFFFFFFFF;
    tick();
    checks++; if (dAck[0] !== 1'b0 || dRdata[0] !== 32'h0000BEEF || memCe[0] !== 1'b0) $display("[TB] FAIL rd_after got ack=%b rdata=%h ce=%b want 0/0000beef/0", dAck[0], dRdata[0], memCe[0]); else passes++;
  endtask

  task automatic test_contention_fixed();
    do_reset();
    dReq = 1'b1; ifReq = 1'b1; dAddr = 32'h40; ifAddr = 32'h200; dSel = 4'hF;
    tick();
    checks++; if (memCe[1] !== 1'b1 || memAddr[1] !== 32'h40 || stall[1] !== 1'b1) $display("[TB] FAIL fp_t1 got ce=%b addr=%h stall=%b want 1/40/1", memCe[1], memAddr[1], stall[1]); else passes++;
    tick();
    checks++; if (dAck[1] !== 1'b1 || ifAck[1] !== 1'b0 || stall[1] !== 1'b1) $display("[TB] FAIL fp_t2 got dack=%b iack=%b stall=%b want 1/0/1", dAck[1], ifAck[1], stall[1]); else passes++;
    dReq = 1'b0;
    tick();
    checks++; if (memCe[1] !== 1'b1 || memAddr[1] !== 32'h200 || dAck[1] !== 1'b0 || stall[1] !== 1'b1) $display("[TB] FAIL fp_t3 got ce=%b addr=%h dack=%b stall=%b want 1/200/0/1", memCe[1], memAddr[1], dAck[1], stall[1]); else passes++;
    tick();
    checks++; if (ifAck[1] !== 1'b1 || dAck[1] !== 1'b0 || stall[1] !== 1'b0) $display("[TB] FAIL fp_t4 got iack=%b dack=%b stall=%b want 1/0/0", ifAck[1], dAck[1], stall[1]); else passes++;
    ifReq = 1'b0;
    tick();
    checks++; if (ifAck[1] !== 1'b0 || memCe[1] !== 1'b0 || stall[1] !== 1'b0) $display("[TB] FAIL fp_t5 got iack=%b ce=%b stall=%b want 0/0/0", ifAck[1], memCe[1], stall[1]); else passes++;
  endtask

  task automatic test_contention_rr();
    do_reset();
    dReq = 1'b1; ifReq = 1'b1; dAddr = 32'h44; ifAddr = 32'h300; dSel = 4'hF;
    tick();
    checks++; if (memCe[2] !== 1'b1 || memAddr[2] !== 32'h300 || memSel[2] !== 4'hF) $display("[TB] FAIL rr_t1 got ce=%b addr=%h sel=%h want 1/300/f", memCe[2], memAddr[2], memSel[2]); else passes++;
    tick();
    checks++; if (ifAck[2] !== 1'b1 || dAck[2] !== 1'b0) $display("[TB] FAIL rr_t2 got iack=%b dack=%b want 1/0", ifAck[2], dAck[2]); else passes++;
    ifReq = 1'b0;
    tick();
    checks++; if (memCe[2] !== 1'b1 || memAddr[2] !== 32'h44) $display("[TB] FAIL rr_t3 got ce=%b addr=%h want 1/44", memCe[2], memAddr[2]); else passes++;
    tick();
    checks++; if (dAck[2] !== 1'b1 || ifAck[2] !== 1'b0) $display("[TB] FAIL rr_t4 got dack=%b iack=%b want 1/0", dAck[2], ifAck[2]); else passes++;
    dReq = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int ackSeen;
    do_reset();
    dReq = 1'b1; dWe = 1'b0; dSel = 4'hF; dAddr = 32'h80;
    tick();
    checks++; if (memCe[0] !== 1'b1 || memAddr[0] !== 32'h80) $display("[TB] FAIL mid_busy got ce=%b addr=%h want 1/80", memCe[0], memAddr[0]); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if (memCe[0] !== 1'b0 || memAddr[0] !== 32'h0) $display("[TB] FAIL mid_async got ce=%b addr=%h want 0/0", memCe[0], memAddr[0]); else passes++;
    @(negedge clk);
    dReq = 1'b0;
    rst = 1'b1;
    ackSeen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dAck[0] === 1'b1 || memCe[0] === 1'b1) ackSeen++;
    end
    checks++; if (ackSeen !== 0) $display("[TB] FAIL mid_no_ack got %0d ack/ce cycles want 0", ackSeen); else passes++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_contention_fixed();
    test_contention_rr();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
